uart_cmd_decode: RTL and testbench
==================================

// Module: uart_cmd_decode
// PURPOSE
//   Parses the byte stream from the UART receiver into SDRAM commands.
//   Sits directly downstream of the UART receiver and consumes its byte/strobe pair.
//   A write packet is a header byte CMD_WR followed by WR_LEN payload bytes.
//   The payload is pushed into the SDRAM write FIFO, then wr_trig starts the burst.
//   A read packet is the single byte CMD_RD and fires rd_trig.
// PARAMETERS
//   CMD_WR   8'h55        header byte of a write packet
//   CMD_RD   8'hAA        single-byte read command
//   WR_LEN   4            payload bytes per write packet (1..15)
//   TIMEOUT  20'd156_250  max idle cycles between bytes inside a write packet (~3 bytes at 9600 baud, 50 MHz)
// PORTS
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous reset, active low
//   uart_flag    in   1  one-cycle strobe: uart_data holds a new byte
//   uart_data    in   8  received byte, valid when uart_flag=1
//   wfifo_full   in   1  SDRAM write FIFO full
//   wfifo_wr_en  out  1  one-cycle push into the write FIFO
//   wfifo_data   out  8  payload byte, valid with wfifo_wr_en
//   wr_trig      out  1  one-cycle pulse: WR_LEN bytes queued, start the SDRAM write
//   rd_trig      out  1  one-cycle pulse: start the SDRAM read
//   cmd_err      out  1  one-cycle pulse: bad header, timeout or FIFO overflow
//   busy         out  1  high while a write packet is in progress
// BEHAVIOUR
//   Clock and reset
//     - One clock domain.
//     - Reset is asynchronous, active-low (rst_n).
//     - Every register and output resets to 0; the FSM resets to IDLE.
//     - Reset mid-packet discards the packet immediately; nothing is flushed from the FIFO.
//   Outputs
//     - All outputs are registered.
//     - Every pulse is exactly one cycle wide.
//   FSM states: IDLE, WR_DATA.
//   IDLE, on uart_flag:
//     - byte==CMD_RD: rd_trig=1 on the next cycle; stay in IDLE.
//     - byte==CMD_WR: go to WR_DATA; byte_cnt=0; to_cnt=0; busy=1 from the next cycle.
//     - any other byte: cmd_err=1 on the next cycle; stay in IDLE.
//     - Without uart_flag, IDLE does nothing.
//   WR_DATA, on uart_flag:
//     - Every byte is payload, including bytes equal to CMD_WR or CMD_RD.
//     - If wfifo_full=0: next cycle wfifo_wr_en=1 and wfifo_data=uart_data.
//       byte_cnt increments; to_cnt clears.
//     - If the pushed byte is the WR_LEN-th: return to IDLE.
//       wr_trig=1 one cycle after that final wfifo_wr_en (two cycles after uart_flag).
//       busy stays high until the cycle wr_trig is asserted, then falls.
//     - If wfifo_full=1: the byte is dropped (no push).
//       cmd_err=1 next cycle; return to IDLE; no wr_trig.
//   WR_DATA, cycles without uart_flag:
//     - to_cnt increments each cycle.
//     - When to_cnt reaches TIMEOUT-1: cmd_err=1 next cycle; return to IDLE; no wr_trig.
//     - If uart_flag and the timeout terminal count land in the same cycle, the byte wins.
//       It is processed normally and to_cnt clears.
//   Counters
//     - byte_cnt: 4 bits, never wraps (bounded by WR_LEN).
//     - to_cnt: 20 bits, saturates by the state exit.
//   Already-queued bytes on an abort stay in the FIFO; the SDRAM side owns the flush.
//   Throughput: uart_flag pulses are >=1 clock apart; every byte is handled with no back-to-back loss.
//   wr_trig and rd_trig are never high in the same cycle.
// TESTING (override TIMEOUT=100 for simulation)
//   1 Bytes 55,11,22,33,44 -> four wfifo_wr_en pulses with data 11,22,33,44;
//     one wr_trig one cycle after the 4th push; busy high throughout, then low; cmd_err never.
//   2 Byte AA -> rd_trig high exactly one cycle, one clock after uart_flag;
//     no wfifo_wr_en, no wr_trig.
//   3 Byte 37 in IDLE -> cmd_err one cycle, no other outputs;
//     a following AA still gives rd_trig.
//   4 Bytes 55,AA,55,AA -> pushes AA,55,AA (payload, not commands); no rd_trig;
//     the 4th payload byte 01 then gives wr_trig.
//   5 Bytes 55,11,22 then 100 idle cycles -> cmd_err on cycle 100 after the last push;
//     busy low; no wr_trig; next full packet works.
//   6 wfifo_full=1 on the 3rd payload byte -> no push for it, cmd_err, FSM back to IDLE.
//     Separately: rst_n pulsed low after 2 payload bytes -> all outputs 0 at once;
//     after release, AA gives rd_trig.

Source files
------------

// File: rtl/uart_cmd_decode_if.sv
// rtl/uart_cmd_decode_if.sv - byte-in / FIFO-push / trigger bundle for uart_cmd_decode
interface uart_cmd_decode_if;
    logic       uart_flag;
    logic [7:0] uart_data;
    logic       wfifo_full;
    logic       wfifo_wr_en;
    logic [7:0] wfifo_data;
    logic       wr_trig;
    logic       rd_trig;
    logic       cmd_err;
    logic       busy;

    modport master (
        output uart_flag, uart_data, wfifo_full,
        input  wfifo_wr_en, wfifo_data, wr_trig, rd_trig, cmd_err, busy
    );

    modport slave (
        input  uart_flag, uart_data, wfifo_full,
        output wfifo_wr_en, wfifo_data, wr_trig, rd_trig, cmd_err, busy
    );
endinterface

// File: rtl/uart_cmd_decode.sv
// rtl/uart_cmd_decode.sv - UART byte stream to SDRAM write/read command decoder
module uart_cmd_decode #(
    parameter logic [7:0]  CMD_WR  = 8'h55,
    parameter logic [7:0]  CMD_RD  = 8'hAA,
    parameter int unsigned WR_LEN  = 4,
    parameter logic [19:0] TIMEOUT = 20'd156_250
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_cmd_decode_if.slave  bus
);
    localparam logic [3:0]  LAST_IDX = 4'(WR_LEN - 1);
    localparam logic [19:0] TO_LAST  = TIMEOUT - 20'd1;

    typedef enum logic {IDLE, WR_DATA} state_t;

    state_t      state_q, state_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [19:0] to_cnt_q, to_cnt_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  data_q, data_d;
    logic        trig_pend_q, trig_pend_d;
    logic        rd_pend_q, rd_pend_d;
    logic        wr_trig_q, wr_trig_d;
    logic        rd_trig_q, rd_trig_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    // State and registered outputs; reset drops any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_cnt_q  <= 4'd0;
            to_cnt_q    <= 20'd0;
            wr_en_q     <= 1'b0;
            data_q      <= 8'd0;
            trig_pend_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            wr_trig_q   <= 1'b0;
            rd_trig_q   <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            to_cnt_q    <= to_cnt_d;
            wr_en_q     <= wr_en_d;
            data_q      <= data_d;
            trig_pend_q <= trig_pend_d;
            rd_pend_q   <= rd_pend_d;
            wr_trig_q   <= wr_trig_d;
            rd_trig_q   <= rd_trig_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state decode: header/command parsing in IDLE, payload push and idle timeout in WR_DATA.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        to_cnt_d    = to_cnt_q;
        wr_en_d     = 1'b0;
        data_d      = data_q;
        trig_pend_d = 1'b0;
        rd_pend_d   = 1'b0;
        wr_trig_d   = trig_pend_q;
        rd_trig_d   = rd_pend_q;
        err_d       = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                // busy falls in the same cycle the pending wr_trig goes out
                busy_d = 1'b0;
                if (bus.uart_flag) begin
                    if (bus.uart_data == CMD_RD) begin
                        // a read landing right behind a write's trigger slips one cycle
                        // so wr_trig and rd_trig never coincide
                        if (trig_pend_q) rd_pend_d = 1'b1;
                        else             rd_trig_d = 1'b1;
                    end else if (bus.uart_data == CMD_WR) begin
                        state_d    = WR_DATA;
                        byte_cnt_d = 4'd0;
                        to_cnt_d   = 20'd0;
                        busy_d     = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WR_DATA: begin
                if (bus.uart_flag) begin
                    // a byte beats a same-cycle timeout terminal count
                    to_cnt_d = 20'd0;
                    if (bus.wfifo_full) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        wr_en_d    = 1'b1;
                        data_d     = bus.uart_data;
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        if (byte_cnt_q == LAST_IDX) begin
                            state_d     = IDLE;
                            trig_pend_d = 1'b1;
                        end
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + 20'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.wfifo_wr_en = wr_en_q;
    assign bus.wfifo_data  = data_q;
    assign bus.wr_trig     = wr_trig_q;
    assign bus.rd_trig     = rd_trig_q;
    assign bus.cmd_err     = err_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_uart_cmd_decode.sv
// tb/tb_uart_cmd_decode.sv - directed vector bench for uart_cmd_decode
module tb_uart_cmd_decode;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    uart_cmd_decode_if bus();

    uart_cmd_decode #(
        .CMD_WR (8'h55),
        .CMD_RD (8'hAA),
        .WR_LEN (4),
        .TIMEOUT(20'd100)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       full;
        logic       e_wr;
        logic       e_rd;
        logic       e_err;
        logic       e_trig;
        logic       e_busy;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int exp_trig = 0;
    int exp_rd = 0;
    int wr_trig_cnt = 0;
    int rd_trig_cnt = 0;
    int overlap_cnt = 0;
    int wide_cnt = 0;
    logic prev_wr = 1'b0;
    logic prev_rd = 1'b0;
    logic prev_err = 1'b0;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] d, input logic f, input logic wr,
                                input logic rd, input logic er, input logic tr, input logic bz);
        vec_t v;
        v.data = d; v.full = f; v.e_wr = wr; v.e_rd = rd;
        v.e_err = er; v.e_trig = tr; v.e_busy = bz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one byte, check the cycle after capture, then the cycle after that.
    task automatic apply(input vec_t v);
        @(negedge clk);
        bus.uart_data  = v.data;
        bus.wfifo_full = v.full;
        bus.uart_flag  = 1'b1;
        @(negedge clk);
        bus.uart_flag  = 1'b0;
        bus.wfifo_full = 1'b0;
        chk($sformatf("wr_en[%0h]", v.data), {7'd0, bus.wfifo_wr_en}, {7'd0, v.e_wr});
        chk($sformatf("rd_trig[%0h]", v.data), {7'd0, bus.rd_trig}, {7'd0, v.e_rd});
        chk($sformatf("cmd_err[%0h]", v.data), {7'd0, bus.cmd_err}, {7'd0, v.e_err});
        chk($sformatf("early_wr_trig[%0h]", v.data), {7'd0, bus.wr_trig}, 8'd0);
        if (v.e_wr) chk($sformatf("wfifo_data[%0h]", v.data), bus.wfifo_data, v.data);
        @(negedge clk);
        chk($sformatf("wr_trig[%0h]", v.data), {7'd0, bus.wr_trig}, {7'd0, v.e_trig});
        chk($sformatf("busy[%0h]", v.data), {7'd0, bus.busy}, {7'd0, v.e_busy});
        if (v.e_trig) exp_trig++;
        if (v.e_rd) exp_rd++;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_en"}, {7'd0, bus.wfifo_wr_en}, 8'd0);
        chk({tag, "_data"}, bus.wfifo_data, 8'd0);
        chk({tag, "_wr_trig"}, {7'd0, bus.wr_trig}, 8'd0);
        chk({tag, "_rd_trig"}, {7'd0, bus.rd_trig}, 8'd0);
        chk({tag, "_cmd_err"}, {7'd0, bus.cmd_err}, 8'd0);
        chk({tag, "_busy"}, {7'd0, bus.busy}, 8'd0);
    endtask

    // Pulse bookkeeping: totals, width and wr/rd exclusivity.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_trig) wr_trig_cnt++;
            if (bus.rd_trig) rd_trig_cnt++;
            if (bus.wr_trig && bus.rd_trig) overlap_cnt++;
            if ((bus.wr_trig && prev_wr) || (bus.rd_trig && prev_rd) || (bus.cmd_err && prev_err))
                wide_cnt++;
        end
        prev_wr  = bus.wr_trig;
        prev_rd  = bus.rd_trig;
        prev_err = bus.cmd_err;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        bus.uart_flag  = 1'b0;
        bus.uart_data  = 8'h00;
        bus.wfifo_full = 1'b0;

        // full write packet
        vecs.push_back(mk(8'h55, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(8'h11, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(8'h22, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(8'h33, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(8'h44, 0, 1, 0, 0, 1, 0));
        // read command
        vecs.push_back(mk(8'hAA, 0, 0, 1, 0, 0, 0));
        // bad header then read
        vecs.push_back(mk(8'h37, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(8'hAA, 0, 0, 1, 0, 0, 0));
        // command bytes inside payload
        vecs.push_back(mk(8'h55, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(8'hAA, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(8'h55, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(8'hAA, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(8'h01, 0, 1, 0, 0, 1, 0));
        // FIFO full on third payload byte, then FSM back in IDLE
        vecs.push_back(mk(8'h55, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(8'h11, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(8'h22, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(8'h33, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(8'hAA, 0, 0, 1, 0, 0, 0));

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // idle timeout: cmd_err exactly 100 cycles after the last push
        apply(mk(8'h55, 0, 0, 0, 0, 0, 1));
        apply(mk(8'h11, 0, 1, 0, 0, 0, 1));
        apply(mk(8'h22, 0, 1, 0, 0, 0, 1));
        found = 0;
        for (int k = 2; k <= 200; k++) begin
            @(negedge clk);
            if (bus.cmd_err) begin
                found = k;
                break;
            end
        end
        chk("timeout_cycle", found[7:0], 8'd100);
        chk("timeout_busy", {7'd0, bus.busy}, 8'd0);
        apply(mk(8'h55, 0, 0, 0, 0, 0, 1));
        apply(mk(8'h01, 0, 1, 0, 0, 0, 1));
        apply(mk(8'h02, 0, 1, 0, 0, 0, 1));
        apply(mk(8'h03, 0, 1, 0, 0, 0, 1));
        apply(mk(8'h04, 0, 1, 0, 0, 1, 0));

        // byte arriving on the timeout terminal count is taken as payload
        apply(mk(8'h55, 0, 0, 0, 0, 0, 1));
        apply(mk(8'h11, 0, 1, 0, 0, 0, 1));
        repeat (97) @(negedge clk);
        apply(mk(8'h22, 0, 1, 0, 0, 0, 1));
        apply(mk(8'h33, 0, 1, 0, 0, 0, 1));
        apply(mk(8'h44, 0, 1, 0, 0, 1, 0));

        // asynchronous reset mid-packet discards it
        apply(mk(8'h55, 0, 0, 0, 0, 0, 1));
        apply(mk(8'h11, 0, 1, 0, 0, 0, 1));
        apply(mk(8'h22, 0, 1, 0, 0, 0, 1));
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(8'h33, 0, 0, 0, 1, 0, 0));
        apply(mk(8'hAA, 0, 0, 1, 0, 0, 0));

        repeat (3) @(negedge clk);
        chk("wr_trig_total", wr_trig_cnt[7:0], exp_trig[7:0]);
        chk("rd_trig_total", rd_trig_cnt[7:0], exp_rd[7:0]);
        chk("trig_overlap", overlap_cnt[7:0], 8'd0);
        chk("pulse_width", wide_cnt[7:0], 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
